nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 118 +++++++++++
 tb/tb_nibble_serial_adder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit ripple slice reused once per clock, LSB nibble first.
// Optional SERIAL_SUB_EN adds a 'sub' port for two's-complement subtraction (a - b).
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Handshake: start is a request that is honoured only in IDLE or DONE;
    // busy is high while nibbles are being processed; done is a one-cycle
    // pulse marking s/c_out/ovf valid, which then hold until the next accept.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic            carry_q;
    logic            sub_q;
    logic            sub_in;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            last;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      sum_nib;
    logic [4:0]      cy;

`ifdef SERIAL_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == IW'(N - 1));

    // Four full-adder cells; cy[i] is the carry into bit i, cy[4] the slice carry-out.
    always_comb begin
        a_nib   = a_q[idx*4 +: 4];
        b_nib   = b_q[idx*4 +: 4] ^ {4{sub_q}};
        sum_nib = '0;
        cy      = '0;
        cy[0]   = carry_q;
        for (int i = 0; i < 4; i++) begin
            sum_nib[i] = a_nib[i] ^ b_nib[i] ^ cy[i];
            cy[i+1]    = (a_nib[i] & b_nib[i]) | (cy[i] & (a_nib[i] ^ b_nib[i]));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            idx     <= '0;
            s       <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                sub_q   <= sub_in;
                // Subtraction is a + ~b + 1, so the initial carry ignores c_in.
                carry_q <= sub_in | c_in;
                idx     <= '0;
                s       <= '0;
            end else if (state == RUN) begin
                s[idx*4 +: 4] <= sum_nib;
                carry_q       <= cy[4];
                idx           <= idx + 1'b1;
                if (last) begin
                    c_out <= cy[4];
                    ovf   <= cy[3] ^ cy[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed and random operations
// compared against a plain-arithmetic reference model through an expected queue.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;
    logic         busy;
    logic         done;

    int total;
    int bad;

    // {ovf, c_out, s}
    logic [W+1:0] exp_q[$];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
`ifdef SERIAL_SUB_EN
        .sub     (sub),
`endif
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .s       (s),
        .c_out   (c_out),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                               input logic tc, input logic ts);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         cc;
        logic         o;
        bb   = ts ? ~tb_v : tb_v;
        cc   = ts ? 1'b1 : tc;
        full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, cc};
        o    = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
        return {o, full[W], full[W-1:0]};
    endfunction

    function automatic logic rand_sub();
`ifdef SERIAL_SUB_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_result(input string tag);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: done seen with empty expected queue", tag);
        end else begin
            e = exp_q.pop_front();
            total++;
            if (s !== e[W-1:0]) begin
                bad++; $display("FAIL %s sum: got %h want %h", tag, s, e[W-1:0]);
            end
            total++;
            if (c_out !== e[W]) begin
                bad++; $display("FAIL %s c_out: got %b want %b", tag, c_out, e[W]);
            end
            total++;
            if (ovf !== e[W+1]) begin
                bad++; $display("FAIL %s ovf: got %b want %b", tag, ovf, e[W+1]);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input string tag);
        int lat;
        int busy_cnt;
        bit got;
        exp_q.push_back(ref_model(ta, tb_v, tc, ts));
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; sub = ts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // operands must not be resampled while running
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = rand_sub();
        lat = 0; busy_cnt = 0; got = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                got = 1; lat = k;
            end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL %s timeout: no done within 20 cycles", tag);
            void'(exp_q.pop_front());
        end else begin
            check_result(tag);
            total++;
            if (lat != N + 1) begin
                bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, N + 1);
            end
            total++;
            if (busy_cnt != N) begin
                bad++; $display("FAIL %s busy cycles: got %0d want %0d", tag, busy_cnt, N);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({s, c_out, ovf, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset: got s=%h c_out=%b ovf=%b busy=%b done=%b want all 0",
                     s, c_out, ovf, busy, done);
        end
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "basic_add");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_wrap");
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "carry_in");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "signed_ovf");
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, "neg_ovf");
        // result held in IDLE
        repeat (4) @(negedge clk);
        total++;
        if (s !== 16'h0000 || c_out !== 1'b1 || ovf !== 1'b1) begin
            bad++; $display("FAIL hold: got s=%h c_out=%b ovf=%b want 0000 1 1", s, c_out, ovf);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), rand_sub(), "random");
    endtask

    task automatic test_start_during_run();
        int dn;
        logic [W-1:0] s_cap;
        logic [W+1:0] e;
        bit got;
        int lat;
        dn = 0; s_cap = '0;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin dn++; s_cap = s; end
            if (k == 2) begin
                a = 16'hAAAA; b = 16'h5555; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        total++;
        if (dn != 1) begin
            bad++; $display("FAIL ignore_start done count: got %0d want 1", dn);
        end
        total++;
        if (s_cap !== 16'h0002 || s !== 16'h0002) begin
            bad++; $display("FAIL ignore_start sum: got %h/%h want 0002", s_cap, s);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL ignore_start idle: got busy=%b want 0", busy);
        end

        // restart from the DONE cycle: no IDLE gap
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "pre_restart");
        exp_q.push_back(ref_model(16'hAAAA, 16'h5555, 1'b0, 1'b0));
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || s !== 16'h0000) begin
            bad++;
            $display("FAIL restart_in_done: got busy=%b done=%b s=%h want 1 0 0000", busy, done, s);
        end
        got = 0; lat = 1;
        for (int k = 2; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (done) begin got = 1; lat = k; end
        end
        total++;
        if (!got || lat != N + 1) begin
            bad++; $display("FAIL restart latency: got %0d (done=%b) want %0d", lat, got, N + 1);
            if (!got) e = exp_q.pop_front();
        end
        if (got) check_result("restart_in_done");
    endtask

    task automatic test_back_to_back();
        int last_k;
        int results;
        logic [W-1:0] ta;
        logic [W-1:0] tb_v;
        logic tc;
        last_k = 0; results = 0;
        @(negedge clk);
        ta = W'($urandom); tb_v = W'($urandom); tc = 1'($urandom);
        exp_q.push_back(ref_model(ta, tb_v, tc, 1'b0));
        a = ta; b = tb_v; c_in = tc; sub = 1'b0; start = 1'b1;
        for (int k = 1; k <= 40 && results < 4; k++) begin
            @(negedge clk);
            if (done) begin
                results++;
                check_result("back_to_back");
                total++;
                if (k - last_k != N + 1) begin
                    bad++; $display("FAIL b2b period: got %0d want %0d", k - last_k, N + 1);
                end
                last_k = k;
                if (results < 4) begin
                    ta = W'($urandom); tb_v = W'($urandom); tc = 1'($urandom);
                    exp_q.push_back(ref_model(ta, tb_v, tc, 1'b0));
                    a = ta; b = tb_v; c_in = tc;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++;
        if (results != 4) begin
            bad++; $display("FAIL b2b count: got %0d want 4", results);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);  // now idx = 2
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (s !== '0 || busy !== 1'b0 || done !== 1'b0 || c_out !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got s=%h busy=%b done=%b c_out=%b ovf=%b want all 0",
                     s, busy, done, c_out, ovf);
        end
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dn++;
        end
        total++;
        if (dn != 0) begin
            bad++; $display("FAIL mid_reset done pulses: got %0d want 0", dn);
        end
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, "after_reset");
    endtask

`ifdef SERIAL_SUB_EN
    task automatic test_sub();
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, "sub_plain");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub0_add");
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
        test_reset();
        test_basic();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_SUB_EN
        test_sub();
`endif
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
